prvp_spi_slave_regfile: RTL and testbench
=========================================

Name: prvp_spi_slave_regfile

Overview:
Parametrised configuration/status register file for the PRVP SPI slave, clocked by the SPI serial clock. It generalises the fixed four-byte configuration bank to a configurable register count, width and wrap-length size. It adds atomic multi-byte commit, a write-lock, sticky error flags and a saturating rejected-write counter. It sits between the SPI slave command decoder (write/read byte strobes) and the slave datapath, which consumes dummy_cycles, en_qpi and wrap_length.

Parameters:
REG_SIZE, 8, register width in bits; must be >= 8
NUM_REGS, 8, number of implemented registers; must be >= WRAP_BYTES+4
ADDR_W, 3, address width; must satisfy 2**ADDR_W >= NUM_REGS
WRAP_BYTES, 2, number of REG_SIZE registers forming wrap_length
DUMMY_RST, 32, reset value of the DUMMY register

Ports:
sclk  in  1  clock, all state on rising edge
rstn  in  1  reset, synchronous, active-low
wr_data  in  REG_SIZE  write data
wr_addr  in  ADDR_W  write register index
wr_data_valid  in  1  write strobe, one write per asserted cycle
rd_addr  in  ADDR_W  read register index
rd_data  out  REG_SIZE  read data, combinational from rd_addr
dummy_cycles  out  REG_SIZE  DUMMY register
en_qpi  out  1  CTRL[0]
wrap_en  out  1  CTRL[2]
locked  out  1  CTRL[1]
wrap_length  out  WRAP_BYTES*REG_SIZE  committed wrap length
wrap_update  out  1  one-cycle pulse, wrap_length changed this cycle
err_irq  out  1  OR of STATUS[1:0]

Behaviour:
- Reset is synchronous: on a rising sclk with rstn=0, all registers clear except DUMMY=DUMMY_RST, and wrap_length=0, wrap_update=0, err_irq=0. Reset has priority over any same-cycle write.
- Register map:
  - 0 CTRL: bit0 en_qpi, bit1 lock, bit2 wrap_en; other bits read 0.
  - 1 DUMMY.
  - 2..W+1 WRAP staging registers, W=WRAP_BYTES, little-endian (index 2 is the least-significant byte).
  - W+2 STATUS: bit0 lock_violation, bit1 bad_addr; other bits read 0.
  - W+3 ERRCNT.
  - W+4..NUM_REGS-1 SCRATCH, plain read/write.
- Writes take effect one sclk edge after wr_data_valid is sampled. The register value is visible on rd_data in the following cycle.
- Lock:
  - CTRL[1] is set-only; writing 0 to it is ignored, and only reset clears it.
  - While locked, CTRL bits 0 and 2 remain writable.
  - While locked, writes to DUMMY, WRAP and SCRATCH are rejected.
  - STATUS and ERRCNT are never lock-protected.
- Rejected write: no register update; set STATUS[0]; ERRCNT increments.
- Out-of-range write (wr_addr >= NUM_REGS): no update; set STATUS[1]; ERRCNT increments.
- An out-of-range write while locked counts once and sets only STATUS[1].
- STATUS is write-1-to-clear per bit. A clear and a same-cycle set of the same bit cannot coincide, since only one write occurs per cycle.
- ERRCNT:
  - Saturates at all-ones.
  - Any accepted write to ERRCNT clears it to 0, regardless of data.
- Atomic wrap commit:
  - Writes to WRAP bytes 2..W go to staging only.
  - A write to the top byte (index W+1) updates staging and, on the same edge, loads wrap_length with {wr_data, staging[W..2]}.
  - wrap_update is high for exactly the following cycle.
  - Back-to-back top-byte writes give back-to-back pulses.
  - Lower-byte writes never change wrap_length.
  - If WRAP_BYTES=1, every write to index 2 commits.
- Reads:
  - rd_data reflects current register contents; WRAP indices return staging values.
  - rd_addr >= NUM_REGS returns 0.
  - Reads have no side effects.
- err_irq is registered state derived directly from STATUS bits, with no extra latency beyond the STATUS update.
- Reset mid-sequence (staging partially written): staging and wrap_length both return to 0. No wrap_update pulse occurs.

Test Plan:
- Reset with rstn=0 for 2 edges -> dummy_cycles=32, en_qpi=0, locked=0, wrap_length=0, err_irq=0, ERRCNT reads 0.
- Write WRAP[2]=0x34 -> wrap_length stays 0, wrap_update=0. Then write WRAP[3]=0x12 -> next cycle wrap_length=0x1234 and wrap_update high for 1 cycle.
- Write CTRL=0x03, then DUMMY=0x08 -> dummy_cycles stays 32, STATUS=0x01, ERRCNT=1, err_irq=1. Write CTRL=0x00 -> locked stays 1, en_qpi=0.
- Write STATUS=0x01 -> STATUS=0, err_irq=0. Write addr 7 with NUM_REGS=6 -> STATUS=0x02, read of addr 7 returns 0.
- 300 rejected writes -> ERRCNT=0xFF (saturated). Write ERRCNT=0x5A -> ERRCNT=0.
- Write WRAP[2]=0x55, then assert rstn=0 -> staging reads 0, wrap_length=0, no wrap_update pulse. Reset asserted in the same cycle as a DUMMY write -> DUMMY=32.

Source files
------------

// File: rtl/prvp_spi_slave_regfile_if.sv
`default_nettype none
// ============================================================================
//  Module      : prvp_spi_slave_regfile_if
//  Description : Command-decoder / datapath bundle for the PRVP SPI slave
//                configuration register file.
//  Revision    : 1.0 - initial release
// ============================================================================
interface prvp_spi_slave_regfile_if #(
    parameter int REG_SIZE   = 8,
    parameter int ADDR_W     = 3,
    parameter int WRAP_BYTES = 2
);
    logic [REG_SIZE-1:0]            wr_data;
    logic [ADDR_W-1:0]              wr_addr;
    logic                           wr_data_valid;
    logic [ADDR_W-1:0]              rd_addr;
    logic [REG_SIZE-1:0]            rd_data;
    logic [REG_SIZE-1:0]            dummy_cycles;
    logic                           en_qpi;
    logic                           wrap_en;
    logic                           locked;
    logic [WRAP_BYTES*REG_SIZE-1:0] wrap_length;
    logic                           wrap_update;
    logic                           err_irq;

    modport slave (
        input  wr_data, wr_addr, wr_data_valid, rd_addr,
        output rd_data, dummy_cycles, en_qpi, wrap_en, locked,
               wrap_length, wrap_update, err_irq
    );

    modport master (
        output wr_data, wr_addr, wr_data_valid, rd_addr,
        input  rd_data, dummy_cycles, en_qpi, wrap_en, locked,
               wrap_length, wrap_update, err_irq
    );
endinterface
`default_nettype wire

// File: rtl/prvp_spi_slave_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : prvp_spi_slave_regfile
//  Description : Parametrised SPI-slave config/status register file with
//                write-lock, sticky errors and atomic wrap_length commit.
//  Revision    : 1.0 - initial release
// ============================================================================
module prvp_spi_slave_regfile #(
    parameter int REG_SIZE   = 8,
    parameter int NUM_REGS   = 8,
    parameter int ADDR_W     = 3,
    parameter int WRAP_BYTES = 2,
    parameter int DUMMY_RST  = 32
) (
    input  wire logic               sclk,
    input  wire logic               rstn,
    prvp_spi_slave_regfile_if.slave bus
);
    localparam int C_CTRL    = 0;
    localparam int C_DUMMY   = 1;
    localparam int C_WRAP_LO = 2;
    localparam int C_WRAP_HI = WRAP_BYTES + 1;
    localparam int C_STATUS  = WRAP_BYTES + 2;
    localparam int C_ERRCNT  = WRAP_BYTES + 3;

    localparam logic [ADDR_W-1:0]   C_A_CTRL    = ADDR_W'(C_CTRL);
    localparam logic [ADDR_W-1:0]   C_A_WRAP_HI = ADDR_W'(C_WRAP_HI);
    localparam logic [ADDR_W-1:0]   C_A_STATUS  = ADDR_W'(C_STATUS);
    localparam logic [ADDR_W-1:0]   C_A_ERRCNT  = ADDR_W'(C_ERRCNT);
    localparam logic [ADDR_W:0]     C_NUM       = (ADDR_W+1)'(NUM_REGS);
    localparam logic [REG_SIZE-1:0] C_DUMMY_RST = REG_SIZE'(DUMMY_RST);
    localparam logic [REG_SIZE-1:0] C_ONES      = '1;

    logic [REG_SIZE-1:0]            r_mem [NUM_REGS];
    logic [WRAP_BYTES*REG_SIZE-1:0] r_wrap_length;
    logic                           r_wrap_update;
    logic                           r_err_irq;

    logic                           w_oob;
    logic                           w_rd_oob;
    logic                           w_protected;
    logic                           w_reject;
    logic                           w_accept;
    logic [REG_SIZE-1:0]            w_ctrl_nxt;
    logic [REG_SIZE-1:0]            w_status_nxt;
    logic [REG_SIZE-1:0]            w_errcnt_nxt;
    logic [WRAP_BYTES*REG_SIZE-1:0] w_wrap_commit;

    assign w_oob       = ({1'b0, bus.wr_addr} >= C_NUM);
    assign w_rd_oob    = ({1'b0, bus.rd_addr} >= C_NUM);
    assign w_protected = (bus.wr_addr != C_A_CTRL) && (bus.wr_addr != C_A_STATUS) &&
                         (bus.wr_addr != C_A_ERRCNT);
    // Out-of-range takes precedence so a locked out-of-range write counts once as bad_addr
    assign w_reject    = !w_oob && r_mem[C_CTRL][1] && w_protected;
    assign w_accept    = bus.wr_data_valid && !w_oob && !w_reject;

    always_comb begin
        w_ctrl_nxt    = '0;
        w_ctrl_nxt[0] = bus.wr_data[0];
        w_ctrl_nxt[1] = r_mem[C_CTRL][1] | bus.wr_data[1];
        w_ctrl_nxt[2] = bus.wr_data[2];
    end

    always_comb begin
        w_status_nxt = r_mem[C_STATUS];
        w_errcnt_nxt = r_mem[C_ERRCNT];
        if (bus.wr_data_valid) begin
            if (w_oob || w_reject) begin
                if (w_oob) w_status_nxt[1] = 1'b1;
                else       w_status_nxt[0] = 1'b1;
                if (r_mem[C_ERRCNT] != C_ONES) w_errcnt_nxt = r_mem[C_ERRCNT] + 1'b1;
            end else if (bus.wr_addr == C_A_STATUS) begin
                w_status_nxt = r_mem[C_STATUS] & ~bus.wr_data;
            end else if (bus.wr_addr == C_A_ERRCNT) begin
                w_errcnt_nxt = '0;
            end
        end
    end

    always_comb begin
        w_wrap_commit = '0;
        for (int i = 0; i < WRAP_BYTES - 1; i++)
            w_wrap_commit[i*REG_SIZE +: REG_SIZE] = r_mem[C_WRAP_LO + i];
        w_wrap_commit[(WRAP_BYTES-1)*REG_SIZE +: REG_SIZE] = bus.wr_data;
    end

    always_ff @(posedge sclk) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
            r_mem[C_DUMMY] <= C_DUMMY_RST;
            r_wrap_length  <= '0;
            r_wrap_update  <= 1'b0;
            r_err_irq      <= 1'b0;
        end else begin
            r_wrap_update    <= 1'b0;
            r_mem[C_STATUS]  <= w_status_nxt;
            r_mem[C_ERRCNT]  <= w_errcnt_nxt;
            r_err_irq        <= |w_status_nxt[1:0];
            if (w_accept) begin
                if (bus.wr_addr == C_A_CTRL)
                    r_mem[C_CTRL] <= w_ctrl_nxt;
                else if (w_protected)
                    r_mem[bus.wr_addr] <= bus.wr_data;
                if (bus.wr_addr == C_A_WRAP_HI) begin
                    r_wrap_length <= w_wrap_commit;
                    r_wrap_update <= 1'b1;
                end
            end
        end
    end

    assign bus.rd_data      = w_rd_oob ? '0 : r_mem[bus.rd_addr];
    assign bus.dummy_cycles = r_mem[C_DUMMY];
    assign bus.en_qpi       = r_mem[C_CTRL][0];
    assign bus.locked       = r_mem[C_CTRL][1];
    assign bus.wrap_en      = r_mem[C_CTRL][2];
    assign bus.wrap_length  = r_wrap_length;
    assign bus.wrap_update  = r_wrap_update;
    assign bus.err_irq      = r_err_irq;
endmodule
`default_nettype wire

// File: tb/tb_prvp_spi_slave_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prvp_spi_slave_regfile
//  Description : Scoreboard bench for prvp_spi_slave_regfile (NUM_REGS=6).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prvp_spi_slave_regfile;
    localparam int C_RS = 8;
    localparam int C_AW = 3;
    localparam int C_WB = 2;

    localparam int SEL_RD    = 0;
    localparam int SEL_DUMMY = 1;
    localparam int SEL_QPI   = 2;
    localparam int SEL_LOCK  = 3;
    localparam int SEL_WLEN  = 4;
    localparam int SEL_WUPD  = 5;
    localparam int SEL_IRQ   = 6;
    localparam int SEL_WEN   = 7;

    logic sclk = 1'b0;
    logic rstn;

    prvp_spi_slave_regfile_if #(.REG_SIZE(C_RS), .ADDR_W(C_AW), .WRAP_BYTES(C_WB)) bus ();

    prvp_spi_slave_regfile #(
        .REG_SIZE(C_RS), .NUM_REGS(6), .ADDR_W(C_AW), .WRAP_BYTES(C_WB), .DUMMY_RST(32)
    ) dut (
        .sclk (sclk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    always #5 sclk = ~sclk;

    string       name_q [$];
    int          sel_q  [$];
    logic [31:0] exp_q  [$];
    logic [31:0] wrap_q [$];

    int n_checks = 0;
    int n_pass   = 0;
    bit done     = 1'b0;
    bit final_chk = 1'b0;

    // Single monitor owns the counters: register/output checks plus wrap_update scoreboard
    always @(negedge sclk) begin
        logic [31:0] act;
        string       nm;
        int          sel;
        logic [31:0] ex;
        while (sel_q.size() > 0) begin
            nm  = name_q.pop_front();
            sel = sel_q.pop_front();
            ex  = exp_q.pop_front();
            case (sel)
                SEL_RD:    act = 32'(bus.rd_data);
                SEL_DUMMY: act = 32'(bus.dummy_cycles);
                SEL_QPI:   act = 32'(bus.en_qpi);
                SEL_LOCK:  act = 32'(bus.locked);
                SEL_WLEN:  act = 32'(bus.wrap_length);
                SEL_WUPD:  act = 32'(bus.wrap_update);
                SEL_IRQ:   act = 32'(bus.err_irq);
                default:   act = 32'(bus.wrap_en);
            endcase
            n_checks++;
            if (act === ex) n_pass++;
            else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, ex);
        end
        if (bus.wrap_update === 1'b1) begin
            n_checks++;
            if (wrap_q.size() == 0) begin
                $display("FAIL unexpected_wrap_update: got pulse with wrap_length 0x%0h expected none",
                         bus.wrap_length);
            end else begin
                ex = wrap_q.pop_front();
                if (32'(bus.wrap_length) === ex) n_pass++;
                else $display("FAIL wrap_commit: got 0x%0h expected 0x%0h", bus.wrap_length, ex);
            end
        end
        if (done && !final_chk) begin
            final_chk = 1'b1;
            n_checks++;
            if (wrap_q.size() == 0) n_pass++;
            else $display("FAIL missing_wrap_update: got %0d pending expected 0", wrap_q.size());
        end
    end

    task automatic check(input string nm, input int sel, input int addr, input logic [31:0] ex);
        bus.rd_addr = C_AW'(addr);
        name_q.push_back(nm);
        sel_q.push_back(sel);
        exp_q.push_back(ex);
        @(negedge sclk);
        #1;
    endtask

    task automatic write(input int addr, input logic [7:0] data);
        bus.wr_addr       = C_AW'(addr);
        bus.wr_data       = data;
        bus.wr_data_valid = 1'b1;
        @(posedge sclk);
        #1;
        bus.wr_data_valid = 1'b0;
    endtask

    task automatic do_reset(input int edges);
        rstn = 1'b0;
        repeat (edges) @(posedge sclk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        rstn              = 1'b0;
        bus.wr_data       = '0;
        bus.wr_addr       = '0;
        bus.wr_data_valid = 1'b0;
        bus.rd_addr       = '0;
        do_reset(2);

        check("rst_dummy",  SEL_DUMMY, 0, 32);
        check("rst_qpi",    SEL_QPI,   0, 0);
        check("rst_lock",   SEL_LOCK,  0, 0);
        check("rst_wlen",   SEL_WLEN,  0, 0);
        check("rst_irq",    SEL_IRQ,   0, 0);
        check("rst_errcnt", SEL_RD,    5, 0);
        check("rst_status", SEL_RD,    4, 0);

        // Staged low byte must not reach wrap_length
        write(2, 8'h34);
        check("lo_wlen",   SEL_WLEN, 0, 0);
        check("lo_wupd",   SEL_WUPD, 0, 0);
        check("lo_stage",  SEL_RD,   2, 8'h34);
        wrap_q.push_back(32'h1234);
        write(3, 8'h12);
        check("hi_wupd",   SEL_WUPD, 0, 1);
        check("hi_wlen",   SEL_WLEN, 0, 32'h1234);
        check("hi_wupd_off", SEL_WUPD, 0, 0);
        check("hi_stage",  SEL_RD,   3, 8'h12);

        wrap_q.push_back(32'hAB34);
        wrap_q.push_back(32'hCD34);
        write(3, 8'hAB);
        write(3, 8'hCD);
        check("b2b_wlen",  SEL_WLEN, 0, 32'hCD34);

        write(0, 8'h05);
        check("ctrl_qpi",  SEL_QPI,  0, 1);
        check("ctrl_wen",  SEL_WEN,  0, 1);
        check("ctrl_lock", SEL_LOCK, 0, 0);
        write(1, 8'h10);
        check("dummy_wr",  SEL_DUMMY, 0, 8'h10);

        write(0, 8'h03);
        check("lock_set",  SEL_LOCK, 0, 1);
        check("lock_wen",  SEL_WEN,  0, 0);
        write(1, 8'h08);
        check("lock_dummy",  SEL_DUMMY, 0, 8'h10);
        check("lock_status", SEL_RD,    4, 8'h01);
        check("lock_errcnt", SEL_RD,    5, 1);
        check("lock_irq",    SEL_IRQ,   0, 1);
        write(3, 8'hEE);
        check("lock_wlen",   SEL_WLEN,  0, 32'hCD34);
        check("lock_errcnt2", SEL_RD,   5, 2);
        write(0, 8'h00);
        check("lock_sticky", SEL_LOCK,  0, 1);
        check("lock_qpi",    SEL_QPI,   0, 0);
        check("lock_ctrl_rd", SEL_RD,   0, 8'h02);

        write(4, 8'h01);
        check("w1c_status",  SEL_RD,  4, 0);
        check("w1c_irq",     SEL_IRQ, 0, 0);
        write(7, 8'hAA);
        check("oob_status",  SEL_RD,  4, 8'h02);
        check("oob_irq",     SEL_IRQ, 0, 1);
        check("oob_errcnt",  SEL_RD,  5, 3);
        check("oob_rd7",     SEL_RD,  7, 0);
        check("oob_rd6",     SEL_RD,  6, 0);
        write(4, 8'h02);
        check("w1c_bad",     SEL_RD,  4, 0);

        for (int i = 0; i < 300; i++) write(1, 8'h08);
        check("errcnt_sat",  SEL_RD,  5, 8'hFF);
        write(5, 8'h5A);
        check("errcnt_clr",  SEL_RD,  5, 0);

        do_reset(1);
        write(2, 8'h55);
        check("mid_stage",   SEL_RD,  2, 8'h55);
        do_reset(1);
        check("mid_stage_rst", SEL_RD,   2, 0);
        check("mid_wlen_rst",  SEL_WLEN, 0, 0);
        check("mid_wupd_rst",  SEL_WUPD, 0, 0);

        rstn              = 1'b0;
        bus.wr_addr       = 3'd1;
        bus.wr_data       = 8'h08;
        bus.wr_data_valid = 1'b1;
        @(posedge sclk);
        #1;
        bus.wr_data_valid = 1'b0;
        rstn              = 1'b1;
        check("rst_prio_dummy", SEL_DUMMY, 0, 32);

        done = 1'b1;
        repeat (3) @(negedge sclk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
